uart_byte_rx: RTL and testbench
===============================

// Module: uart_byte_rx
// PURPOSE
//  - UART receive front end for the bootloader. Format is 8N1, LSB first.
//  - Synchronises the raw uart_rx pin and recovers one byte per frame.
//  - Each byte is handed downstream on a valid/ready handshake, through a one-byte holding register.
//  - Sits directly upstream of the bootloader command parser. That parser consumes the byte stream
//    (command, 16-bit LE lengths, payload) that drives the SPI flash transfers.
// PARAMETERS
//  - CLKS_PER_BIT  1250  clk cycles per UART bit (12 MHz / 9600 baud). Legal range: >= 8.
//  - MID           CLKS_PER_BIT/2 (localparam, integer division). Sample offset from the bit start.
// PORTS
//  - clk        in   1  system clock (12 MHz)
//  - rst        in   1  reset; asynchronous, active-high
//  - uart_rx    in   1  raw serial line; idles high; asynchronous to clk
//  - data       out  8  received byte; stable while valid=1
//  - valid      out  1  data holds an unconsumed byte
//  - ready      in   1  consumer accepts data on a cycle with valid&&ready
//  - frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
//  - overrun    out  1  one-cycle pulse: byte completed while holding register full, new byte dropped
// BEHAVIOUR
//  - Reset values: data=8'h00, valid=0, frame_err=0, overrun=0. Both sync flops =1. State=WAIT_IDLE.
//  - Synchroniser: 2-flop chain. rx_s is the second flop output; it lags uart_rx by 2 clk.
//  - Bit counter: cnt is $clog2(CLKS_PER_BIT) bits wide and runs 0..CLKS_PER_BIT-1.
//  - Bit index: idx is 3 bits.
//  - States and transitions:
//    - WAIT_IDLE: stay until rx_s==1, then go to IDLE. Entered after reset and after a frame error,
//      so a reset released mid-frame or with the line low never starts a false frame.
//    - IDLE: when rx_s==0, go to START with cnt=0.
//    - START: at cnt==MID, sample. If the sample is 0: go to DATA, cnt=0, idx=0.
//      If it is 1: treat as a glitch and return to IDLE with no output.
//    - DATA: at cnt==CLKS_PER_BIT-1 (one bit period after the previous sample point), sample into
//      shift[idx]. Then cnt=0 and idx++. After idx==7 is sampled, go to STOP.
//    - STOP: at cnt==CLKS_PER_BIT-1, sample.
//      - Sample 1: deliver the byte and go to IDLE. IDLE is entered mid-stop-bit, which allows
//        back-to-back frames.
//      - Sample 0: pulse frame_err for 1 cycle, discard the byte and go to WAIT_IDLE.
//  - Delivery, on the cycle after the stop sample:
//    - Holding register free (valid==0, or valid&&ready in that same cycle): data<=shift, valid<=1.
//    - Otherwise: pulse overrun for 1 cycle. data and valid are unchanged and the new byte is lost.
//  - Consumption: valid&&ready with no simultaneous delivery gives valid<=0 next cycle.
//    data keeps its last value.
//  - Latency: the stop sample falls MID+9*CLKS_PER_BIT clk after the first rx_s==0.
//    valid rises 1 clk after that.
//  - Only one of frame_err and overrun can pulse per frame. Both are 0 at all other times.
//  - rst asserted mid-frame: every output goes to its reset value at once (asynchronously).
//    A partially received byte is lost.
// CONFIGURATION
//  - Macro UART_RX_MAJORITY_EN.
//  - Defined: every sample (start, data, stop) is the 2-of-3 majority of rx_s at MID-1, MID and MID+1
//    of that bit. The decision is taken at MID+1, so all sample points and valid shift 1 clk later.
//    A single-cycle glitch at MID is rejected.
//  - Undefined: a single sample of rx_s at MID. No extra sample registers are built.
// TESTING
//  - Run all scenarios with CLKS_PER_BIT=1250 and ready held high unless stated.
//  - After 10 idle bit times, send 0x01,0x02,0x00,0x05,0x00,0x9F,0x00 back-to-back.
//    Required: 7 valid pulses with data in that order, no frame_err, no overrun.
//  - Hold ready=0 and send 0x02 then 0x00.
//    Required: data=0x02 with valid=1 throughout, one overrun pulse after the second stop bit.
//    Then raise ready: valid drops the next cycle.
//  - Send 0x9F with the stop bit driven low.
//    Required: one frame_err pulse, no valid. A following 0x05 sent after the line returns high is
//    received correctly.
//  - Drive uart_rx low for 300 clk, then high.
//    Required: no valid and no frame_err; the FSM is back in IDLE.
//  - Assert rst during bit 3 of 0xA5 with uart_rx held low past reset release, then send 0x5A.
//    Required: all outputs 0 during reset, no byte from the aborted frame, data=0x5A valid.
//  - Send 0xFF with a 1-clk low glitch at MID of bit 4.
//    Required: data=0xEF without UART_RX_MAJORITY_EN; data=0xFF with it.

Source files
------------

// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: received-byte valid/ready handshake plus error pulses.
interface uart_byte_rx_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       overrun;
   modport master (output data, valid, frame_err, overrun, input ready);
   modport slave  (input data, valid, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 LSB-first UART receiver feeding a one-byte valid/ready holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at MID-1/MID/MID+1 of every bit.
module uart_byte_rx #(
   parameter int CLKS_PER_BIT = 1250
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           uart_rx,
   uart_byte_rx_if.master bus
);
   localparam int MID = CLKS_PER_BIT / 2;
   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;
   state_t        state;
   logic          s1, rx_s, samp, done;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shift;
   always_ff @(posedge clk or posedge rst)
      if (rst) {rx_s, s1} <= 2'b11;
      else     {rx_s, s1} <= {s1, uart_rx};
`ifdef UART_RX_MAJORITY_EN
   // The decision waits one extra clk so the sample at MID+1 is available.
   localparam logic [CW-1:0] SP = CW'(MID + 1);
   logic [1:0] h;
   always_ff @(posedge clk or posedge rst)
      if (rst) h <= 2'b11;
      else     h <= {h[0], rx_s};
   assign samp = (h[1] & h[0]) | (h[1] & rx_s) | (h[0] & rx_s);
`else
   localparam logic [CW-1:0] SP = CW'(MID);
   assign samp = rx_s;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state         <= WAIT_IDLE;
         cnt           <= '0;
         idx           <= '0;
         shift         <= '0;
         done          <= 1'b0;
         bus.data      <= 8'h00;
         bus.valid     <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.overrun   <= 1'b0;
      end else begin
         done          <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.overrun   <= 1'b0;
         cnt           <= cnt + 1'b1;
         case (state)
            WAIT_IDLE: if (rx_s) state <= IDLE;
            IDLE: if (!rx_s) begin
               state <= START;
               cnt   <= '0;
            end
            START: if (cnt == SP) begin
               cnt   <= '0;
               idx   <= '0;
               state <= samp ? IDLE : DATA;
            end
            DATA: if (cnt == LAST) begin
               shift[idx] <= samp;
               cnt        <= '0;
               idx        <= idx + 1'b1;
               if (idx == 3'd7) state <= STOP;
            end
            STOP: if (cnt == LAST) begin
               cnt           <= '0;
               state         <= samp ? IDLE : WAIT_IDLE;
               done          <= samp;
               bus.frame_err <= !samp;
            end
            default: state <= WAIT_IDLE;
         endcase
         // A byte may land in the same cycle the consumer frees the register.
         if (done) begin
            if (!bus.valid || bus.ready) begin
               bus.data  <= shift;
               bus.valid <= 1'b1;
            end else bus.overrun <= 1'b1;
         end else if (bus.valid && bus.ready) bus.valid <= 1'b0;
      end
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed scenarios for uart_byte_rx with a short bit period to bound run time.
module tb_uart_byte_rx;
   localparam int C   = 20;
   localparam int MID = C / 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic uart_rx = 1'b1;
   int errors = 0;
   int checks = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   bit hold_mon = 1'b0;
   bit drop_seen = 1'b0;
   logic [7:0] rxq[$];
   logic [7:0] exp_seq[7] = '{8'h01, 8'h02, 8'h00, 8'h05, 8'h00, 8'h9F, 8'h00};
   uart_byte_rx_if bus ();
   uart_byte_rx #(.CLKS_PER_BIT(C)) dut (.clk(clk), .rst(rst), .uart_rx(uart_rx), .bus(bus.master));
   always #5 clk = ~clk;
   always @(negedge clk)
      if (!rst) begin
         if (bus.valid && bus.ready) rxq.push_back(bus.data);
         if (bus.frame_err) fe_cnt++;
         if (bus.overrun) ov_cnt++;
         if (hold_mon && !bus.valid) drop_seen = 1'b1;
      end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic bitn(input logic v, input int n);
      uart_rx = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send(input logic [7:0] b, input logic stop, input int gbit);
      bitn(1'b0, C);
      for (int i = 0; i < 8; i++)
         if (i == gbit) begin
            bitn(b[i], MID + 1);
            bitn(1'b0, 1);
            bitn(b[i], C - MID - 2);
         end else bitn(b[i], C);
      bitn(stop, C);
      uart_rx = 1'b1;
   endtask
   task automatic clear();
      rxq.delete();
      fe_cnt = 0;
      ov_cnt = 0;
   endtask
   initial begin
      bus.ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", 32'(bus.data), 32'h00);
      chk("rst_valid", 32'(bus.valid), 32'h0);
      chk("rst_ferr", 32'(bus.frame_err), 32'h0);
      chk("rst_ovr", 32'(bus.overrun), 32'h0);
      rst = 1'b0;
      bitn(1'b1, 10 * C);
      foreach (exp_seq[i]) send(exp_seq[i], 1'b1, -1);
      bitn(1'b1, C);
      chk("b2b_count", 32'(rxq.size()), 32'd7);
      foreach (exp_seq[i]) chk($sformatf("b2b_byte%0d", i), 32'(rxq[i]), 32'(exp_seq[i]));
      chk("b2b_ferr", 32'(fe_cnt), 32'd0);
      chk("b2b_ovr", 32'(ov_cnt), 32'd0);
      clear();
      bus.ready = 1'b0;
      send(8'h02, 1'b1, -1);
      chk("hold_valid1", 32'(bus.valid), 32'h1);
      chk("hold_data1", 32'(bus.data), 32'h02);
      hold_mon = 1'b1;
      send(8'h00, 1'b1, -1);
      bitn(1'b1, 2);
      chk("hold_ovr", 32'(ov_cnt), 32'd1);
      chk("hold_ferr", 32'(fe_cnt), 32'd0);
      chk("hold_valid2", 32'(bus.valid), 32'h1);
      chk("hold_data2", 32'(bus.data), 32'h02);
      chk("hold_nodrop", 32'(drop_seen), 32'h0);
      hold_mon = 1'b0;
      bus.ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_release", 32'(bus.valid), 32'h0);
      chk("hold_taken", 32'(rxq.size()), 32'd1);
      chk("hold_taken_data", 32'(rxq[0]), 32'h02);
      clear();
      send(8'h9F, 1'b0, -1);
      bitn(1'b1, 2 * C);
      chk("ferr_pulse", 32'(fe_cnt), 32'd1);
      chk("ferr_novalid", 32'(rxq.size()), 32'd0);
      send(8'h05, 1'b1, -1);
      bitn(1'b1, C);
      chk("ferr_next_cnt", 32'(rxq.size()), 32'd1);
      chk("ferr_next_data", 32'(rxq[0]), 32'h05);
      chk("ferr_total", 32'(fe_cnt), 32'd1);
      clear();
      bitn(1'b0, 5);
      bitn(1'b1, 2 * C);
      chk("glitch_novalid", 32'(rxq.size()), 32'd0);
      chk("glitch_noferr", 32'(fe_cnt), 32'd0);
      bus.ready = 1'b0;
      send(8'h3C, 1'b1, -1);
      bitn(1'b1, C);
      chk("glitch_idle_valid", 32'(bus.valid), 32'h1);
      chk("glitch_idle_data", 32'(bus.data), 32'h3C);
      clear();
      bitn(1'b0, C);
      bitn(1'b1, C);
      bitn(1'b0, C);
      bitn(1'b1, C);
      bitn(1'b0, MID);
      rst = 1'b1;
      #1;
      chk("arst_data", 32'(bus.data), 32'h00);
      chk("arst_valid", 32'(bus.valid), 32'h0);
      chk("arst_ferr", 32'(bus.frame_err), 32'h0);
      chk("arst_ovr", 32'(bus.overrun), 32'h0);
      bitn(1'b0, 3);
      rst = 1'b0;
      bitn(1'b0, 3);
      bitn(1'b1, 2 * C);
      chk("arst_noframe", 32'(bus.valid), 32'h0);
      chk("arst_noferr", 32'(fe_cnt), 32'd0);
      bus.ready = 1'b1;
      send(8'h5A, 1'b1, -1);
      bitn(1'b1, C);
      chk("arst_next_cnt", 32'(rxq.size()), 32'd1);
      chk("arst_next_data", 32'(rxq[0]), 32'h5A);
      chk("arst_data_hold", 32'(bus.data), 32'h5A);
      clear();
      send(8'hFF, 1'b1, 4);
      bitn(1'b1, C);
      chk("maj_cnt", 32'(rxq.size()), 32'd1);
`ifdef UART_RX_MAJORITY_EN
      chk("maj_data", 32'(rxq[0]), 32'hFF);
`else
      chk("maj_data", 32'(rxq[0]), 32'hEF);
`endif
      chk("maj_ferr", 32'(fe_cnt), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
